bcd_addsub_serial: RTL and testbench

- Parametrised multi-digit BCD adder/subtractor, processing one decimal digit per clock, least-significant digit first.
- Add mode: A + B + cin. Subtract mode: A − B, returned as sign plus magnitude through a ten's-complement fix-up pass.
- Start/busy/done handshake; sits between operand registers and the BCD display/readout path.
- Replaces chains of single-digit combinational BCD adders.

---
 rtl/bcd_addsub_serial.sv | 162 ++++++++++++++++
 tb/tb_bcd_addsub_serial.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction adds the nine's complement plus one, then runs a ten's-complement pass when the result is negative.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                neg,
  output logic                err,
  output logic                busy,
  output logic                done
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  // Handshake: start is sampled only in S_IDLE; busy covers S_ADD/S_FIX;
  // done is a one-cycle pulse in S_DONE, results hold until the next accepted start.
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sub_q, sub_d, carry_q, carry_d;
  logic               cout_q, cout_d, neg_q, neg_d, err_q, err_d;

  logic [IDX_W+1:0]   base;
  logic [3:0]         a_dig, b_dig, s_dig, b_eff;
  logic [4:0]         z, t;
  logic [3:0]         z_digit, t_digit;
  logic               z_carry, t_carry;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign base  = {idx_q, 2'b00};
  assign a_dig = a_q[base +: 4];
  assign b_dig = b_q[base +: 4];
  assign s_dig = sum_q[base +: 4];

  assign b_eff   = sub_q ? (4'd9 - b_dig) : b_dig;
  assign z       = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry_q};
  assign z_carry = (z > 5'd9);
  assign z_digit = z_carry ? (z[3:0] + 4'd6) : z[3:0];

  assign t       = {1'b0, 4'd9 - s_dig} + {4'd0, carry_q};
  assign t_carry = (t == 5'd10);
  assign t_digit = t_carry ? 4'd0 : t[3:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          sub_d  = sub;
          cout_d = 1'b0;
          neg_d  = 1'b0;
          err_d  = 1'b0;
          if (has_bad_digit(a) || has_bad_digit(b)) begin
            err_d   = 1'b1;
            sum_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = '0;
            carry_d = sub ? 1'b1 : cin;
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        sum_d[base +: 4] = z_digit;
        carry_d          = z_carry;
        idx_d            = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (!sub_q) begin
            cout_d  = z_carry;
            state_d = S_DONE;
          end else if (z_carry) begin
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            // No end-around carry: result is negative, recomplement it.
            neg_d   = 1'b1;
            carry_d = 1'b1;
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        sum_d[base +: 4] = t_digit;
        carry_d          = t_carry;
        idx_d            = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign neg  = neg_q;
  assign err  = err_q;
  assign busy = (state_q == S_ADD) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed plus random checks of bcd_addsub_serial against an integer-arithmetic decimal model.
module tb_bcd_addsub_serial;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MODV   = 10000;

  logic         clk = 1'b0;
  logic         rst_n, start, sub, cin;
  logic [W-1:0] a, b, sum;
  logic         cout, neg, err, busy, done;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sum), .cout(cout), .neg(neg), .err(err),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One operation end to end; optionally pulses a second start mid-operation.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                        input logic tcin, input bit inject);
    int ai, bi, r, exp_lat, lat;
    logic [W-1:0] exp_sum;
    logic exp_cout, exp_neg, exp_err;
    ai = bcd2int(ta);
    bi = bcd2int(tb);
    exp_err = has_bad(ta) || has_bad(tb);
    exp_cout = 1'b0;
    exp_neg  = 1'b0;
    if (exp_err) begin
      exp_sum = '0;
      exp_lat = 1;
    end else if (!tsub) begin
      r        = ai + bi + int'(tcin);
      exp_sum  = int2bcd(r % MODV);
      exp_cout = (r >= MODV);
      exp_lat  = DIGITS + 1;
    end else begin
      exp_neg  = (ai < bi);
      exp_sum  = int2bcd(exp_neg ? bi - ai : ai - bi);
      exp_lat  = exp_neg ? 2 * DIGITS + 1 : DIGITS + 1;
    end
    exp_q.push_back(exp_sum);

    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    if (!exp_err) check("busy_after_start", busy, 1);
    while (!done && lat < 40) begin
      if (inject && lat == 2) begin
        start = 1'b1;
        a = int2bcd($urandom_range(0, MODV - 1));
        b = int2bcd($urandom_range(0, MODV - 1));
        sub = ~tsub; cin = ~tcin;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check("done_seen", done, 1);
    check("latency", lat, exp_lat);
    exp_sum = exp_q.pop_front();
    check("sum", sum, exp_sum);
    check("cout", cout, exp_cout);
    check("neg", neg, exp_neg);
    check("err", err, exp_err);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("sum_hold", sum, exp_sum);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, neg, err, busy, done}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 1'b0);
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0042, 16'h0958, 1'b0, 1'b1, 1'b0);
    run_op(16'h0421, 16'h3377, 1'b0, 1'b0, 1'b1);
    run_op(16'h0421, 16'h3377, 1'b1, 1'b0, 1'b1);
    run_op(16'h7777, 16'h7777, 1'b1, 1'b0, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0);

    // Reset asserted while the ten's-complement pass is running.
    a = 16'h1234; b = 16'h5000; sub = 1'b1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (DIGITS + 2) @(posedge clk);
    #1;
    check("busy_in_fix", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_sum", sum, 0);
    check("midrst_flags", {cout, neg, err, busy, done}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", done, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0815, 16'h4711, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ra = int2bcd($urandom_range(0, MODV - 1));
      rb = ($urandom_range(0, 3) == 0) ? ra : int2bcd($urandom_range(0, MODV - 1));
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
